// File: rtl/yolo_stream_pkg.sv
// yolo_stream_pkg: shared widths and FSM encoding for the feature-map streamer.
// Contents: DATA_W (feature-map word), ADDR_W (buffer address), DIM_W (frame
// dimension) defaults and the controller state type.
package yolo_stream_pkg;
   localparam int DATA_W = 96;
   localparam int ADDR_W = 18;
   localparam int DIM_W  = 10;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/stream_hold_reg.sv
// stream_hold_reg: one-entry skid register parking a read word while downstream is full.
// Ports: i_clk/i_rst clock and sync reset, i_load captures i_data, i_unload empties
// the entry, o_data/o_valid the held word and its occupancy flag.
module stream_hold_reg
   import yolo_stream_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic         i_unload,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_valid
);
   always_ff @(posedge i_clk)
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
      end else if (i_unload)
         o_valid <= 1'b0;
endmodule

// File: rtl/fmap_stream_ctrl.sv
// fmap_stream_ctrl: streams one feature-map frame from a synchronous buffer to a FIFO.
// Ports: Clk/Rst clock and sync reset; start/base_addr/img_width/img_height frame
// request; mem_rd_en/mem_addr/mem_rd_data buffer read port; data_out/valid_out
// registered stream; full downstream almost-full; busy/done status.
module fmap_stream_ctrl
   import yolo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W,
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DIM_WIDTH  = DIM_W
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [DIM_WIDTH-1:0]  img_width,
   input  logic [DIM_WIDTH-1:0]  img_height,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  full,
   output logic                  busy,
   output logic                  done
);
   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DIM_WIDTH-1:0]  r_w, r_h, r_col, r_row;
   logic                  r_pend;
   logic                  w_hold_v, w_last, w_send, w_zero, w_eol;
   logic [DATA_WIDTH-1:0] w_hold_d;

   assign w_zero = (img_width == '0) || (img_height == '0);
   assign w_eol  = r_col == r_w - DIM_WIDTH'(1);
   assign w_last = w_eol && (r_row == r_h - DIM_WIDTH'(1));

   always_ff @(posedge Clk)
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_RUN;
         S_RUN:   if (mem_rd_en && w_last) w_next = S_DRAIN;
         S_DRAIN: if (!r_pend && !w_hold_v) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // A read is only issued when its return is guaranteed a slot: if full rises
   // on the return cycle the word parks in the empty hold register, and no new
   // read goes out until that register drains.
   always_comb begin
      mem_rd_en = (r_state == S_RUN) && !full && !w_hold_v;
      mem_addr  = r_addr;
      busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
      done      = r_state == S_DONE;
   end

   // Row-major order over a contiguous window, so a running address equals
   // base + row*width + col and wraps naturally at 2^ADDR_WIDTH.
   always_ff @(posedge Clk)
      if (Rst) begin
         r_addr <= '0;
         r_w    <= '0;
         r_h    <= '0;
         r_col  <= '0;
         r_row  <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_addr <= base_addr;
         r_w    <= img_width;
         r_h    <= img_height;
         r_col  <= '0;
         r_row  <= '0;
      end else if (mem_rd_en) begin
         r_addr <= r_addr + ADDR_WIDTH'(1);
         r_col  <= w_eol ? '0 : r_col + DIM_WIDTH'(1);
         r_row  <= w_eol ? r_row + DIM_WIDTH'(1) : r_row;
      end

   // The held word always predates a returning one, so it goes out first.
   assign w_send = !full && (w_hold_v || r_pend);

   always_ff @(posedge Clk)
      if (Rst) begin
         r_pend    <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         r_pend    <= mem_rd_en;
         valid_out <= w_send;
         if (w_send) data_out <= w_hold_v ? w_hold_d : mem_rd_data;
      end

   stream_hold_reg #(.W(DATA_WIDTH)) u_hold (
      .i_clk    (Clk),
      .i_rst    (Rst),
      .i_load   (r_pend && full),
      .i_unload (w_hold_v && !full),
      .i_data   (mem_rd_data),
      .o_data   (w_hold_d),
      .o_valid  (w_hold_v)
   );
endmodule

// File: tb/tb_fmap_stream_ctrl.sv
// tb_fmap_stream_ctrl: directed self-checking bench for fmap_stream_ctrl.
module tb_fmap_stream_ctrl;
   localparam int DW = 96;
   localparam int AW = 18;
   localparam int WW = 10;

   logic          Clk = 1'b0;
   logic          Rst, start, full;
   logic [AW-1:0] base_addr, mem_addr;
   logic [WW-1:0] img_width, img_height;
   logic          mem_rd_en, valid_out, busy, done;
   logic [DW-1:0] mem_rd_data, data_out;

   int            checks = 0, failures = 0, cyc = 0;
   int            full_lo = 0, full_hi = 0, full_pat = 0;
   int            addr_q[$], acyc_q[$], vcyc_q[$], done_q[$];
   logic [DW-1:0] data_q[$];
   bit            busy_h[int];
   logic          busy_at_done = 1'b1;

   fmap_stream_ctrl dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .start       (start),
      .base_addr   (base_addr),
      .img_width   (img_width),
      .img_height  (img_height),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .full        (full),
      .busy        (busy),
      .done        (done)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
      return {a, 6'h2A, a, 6'h15, a, 6'h33, a, 6'h0C};
   endfunction

   always @(posedge Clk) mem_rd_data <= mem_rd_en ? mk(mem_addr) : {DW{1'b1}};

   always @(posedge Clk) begin
      #1;
      full = (full_pat != 0) ? ((cyc % 3) == 0) : ((cyc >= full_lo) && (cyc < full_hi));
   end

   always @(negedge Clk) begin
      busy_h[cyc] = busy;
      if (mem_rd_en) begin
         addr_q.push_back(int'(mem_addr));
         acyc_q.push_back(cyc);
      end
      if (valid_out) begin
         data_q.push_back(data_out);
         vcyc_q.push_back(cyc);
      end
      if (done) begin
         done_q.push_back(cyc);
         busy_at_done = busy;
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic int count_in(input int q[$], input int lo, input int hi);
      int n = 0;
      foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
      return n;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic launch(input logic [AW-1:0] b, input logic [WW-1:0] w, input logic [WW-1:0] h, output int s);
      addr_q.delete(); acyc_q.delete(); data_q.delete(); vcyc_q.delete(); done_q.delete();
      busy_at_done = 1'b1;
      base_addr = b; img_width = w; img_height = h; start = 1'b1; s = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      while (done_q.size() == 0 && n < lim) begin
         step(1);
         n++;
      end
      if (done_q.size() == 0) check("done_timeout", 0, 1);
      step(2);
   endtask

   task automatic check_words(input string tag, input logic [AW-1:0] b, input int n);
      logic [AW-1:0] a;
      check({tag, "_nrd"}, addr_q.size(), n);
      check({tag, "_nwd"}, data_q.size(), n);
      for (int i = 0; i < n; i++) begin
         a = b + AW'(i);
         check({tag, "_addr"}, at(addr_q, i), a);
         check({tag, "_data"}, (i < data_q.size()) ? data_q[i] : '0, mk(a));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rd_en"}, mem_rd_en, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_valid"}, valid_out, 0);
      check({tag, "_data"}, data_out, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s;
      Rst = 1'b1; start = 1'b0; full = 1'b0;
      base_addr = '0; img_width = '0; img_height = '0;
      step(3);
      @(negedge Clk);
      check_idle_outputs("reset");
      step(1);
      Rst = 1'b0;
      step(2);

      launch(18'h100, 2, 2, s);
      wait_done(40);
      check_words("f2x2", 18'h100, 4);
      check("f2x2_rd0_cyc", at(acyc_q, 0), s + 1);
      check("f2x2_rd3_cyc", at(acyc_q, 3), s + 4);
      check("f2x2_v0_cyc", at(vcyc_q, 0), s + 3);
      check("f2x2_v3_cyc", at(vcyc_q, 3), s + 6);
      check("f2x2_ndone", done_q.size(), 1);
      check("f2x2_done_cyc", at(done_q, 0), s + 7);
      check("f2x2_busy_in_done", busy_at_done, 0);
      check("f2x2_busy_run", busy_h[s + 2], 1);

      full_lo = cyc + 2;
      full_hi = cyc + 5;
      launch(18'h20, 3, 1, s);
      wait_done(40);
      full_lo = 0;
      full_hi = 0;
      check_words("hold", 18'h20, 3);
      check("hold_no_rd", count_in(acyc_q, s + 2, s + 6), 0);
      check("hold_no_valid", count_in(vcyc_q, s + 3, s + 6), 0);
      check("hold_v0_cyc", at(vcyc_q, 0), s + 6);
      check("hold_done_cyc", at(done_q, 0), s + 10);

      launch(18'h55, 0, 3, s);
      wait_done(10);
      check("zw_nrd", addr_q.size(), 0);
      check("zw_nwd", data_q.size(), 0);
      check("zw_done_cyc", at(done_q, 0), s + 1);
      check("zw_ndone", done_q.size(), 1);
      check("zw_busy_after", busy_h[s + 2], 0);

      launch(18'h56, 4, 0, s);
      wait_done(10);
      check("zh_nrd", addr_q.size(), 0);
      check("zh_done_cyc", at(done_q, 0), s + 1);

      launch(18'h200, 4, 4, s);
      step(3);
      base_addr = 18'h300; img_width = 2; img_height = 2; start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done(80);
      check_words("restart", 18'h200, 16);
      check("restart_ndone", done_q.size(), 1);
      check("restart_done_cyc", at(done_q, 0), s + 19);

      launch(18'h180, 4, 4, s);
      step(4);
      Rst = 1'b1;
      step(1);
      Rst = 1'b0;
      @(negedge Clk);
      check_idle_outputs("midrst");
      check("midrst_nrd", addr_q.size(), 5);
      step(1);
      @(negedge Clk);
      check("midrst_discard", valid_out, 0);
      step(6);
      check("midrst_ndone", done_q.size(), 0);
      check("midrst_nwd", data_q.size(), 3);
      launch(18'h40, 4, 4, s);
      wait_done(80);
      check_words("postrst", 18'h40, 16);
      check("postrst_ndone", done_q.size(), 1);

      launch(18'h3FFFE, 2, 2, s);
      wait_done(40);
      check_words("wrap", 18'h3FFFE, 4);
      check("wrap_a2", at(addr_q, 2), 0);
      check("wrap_a3", at(addr_q, 3), 1);

      full_pat = 1;
      launch(18'h7, 3, 3, s);
      wait_done(100);
      full_pat = 0;
      check_words("toggle", 18'h7, 9);
      check("toggle_ndone", done_q.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
